// File: rtl/bayer_window_engine.sv
// Streaming Bayer 2x2 window engine: caches the previous row and emits one RGGB-ordered window per interior pixel.
// Optional window counter is built when BAYER_WIN_STATS_EN is defined; otherwise win_count is tied to zero.
module bayer_window_engine #(
  parameter int PIX_W     = 8,
  parameter int DIM_W     = 13,
  parameter int MAX_WIDTH = 4096
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [DIM_W-1:0]     image_width,
  input  logic [DIM_W-1:0]     image_height,
  input  logic [PIX_W-1:0]     pix_in,
  input  logic                 pix_in_valid,
  output logic                 pix_in_ready,
  output logic [4*PIX_W-1:0]   win_out,
  output logic [DIM_W-1:0]     win_row,
  output logic [DIM_W-1:0]     win_col,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 busy,
  output logic                 finish_flag,
  output logic                 cfg_err,
  output logic [2*DIM_W-1:0]   win_count
);

  localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [DIM_W-1:0] MAX_W = DIM_W'(MAX_WIDTH);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO   = DIM_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 start_q;
  logic [DIM_W-1:0]     w_q, w_d, h_q, h_d;
  logic [DIM_W-1:0]     col_q, col_d, row_q, row_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 finish_q, finish_d;
  logic                 win_valid_q, win_valid_d;
  logic [4*PIX_W-1:0]   win_q, win_d;
  logic [DIM_W-1:0]     win_row_q, win_row_d, win_col_q, win_col_d;
  logic [PIX_W-1:0]     prev_pix_q, prev_pix_d, prev_old_q, prev_old_d;

  logic [PIX_W-1:0]     cache [MAX_WIDTH];
  logic [PIX_W-1:0]     old_pix;
  logic                 start_edge, accept, win_hs, last_col, last_row;
  logic [PIX_W-1:0]     tl, tr, bl, br;

  assign start_edge   = start & ~start_q;
  assign pix_in_ready = ((state_q == S_FILL) || (state_q == S_STREAM)) &&
                        (!win_valid_q || win_ready);
  assign accept       = pix_in_valid & pix_in_ready;
  assign win_hs       = win_valid_q & win_ready;
  assign old_pix      = cache[col_q[ADDR_W-1:0]];
  assign last_col     = (col_q == w_q - ONE);
  assign last_row     = (row_q == h_q - ONE);

  assign tl = prev_old_q;
  assign tr = old_pix;
  assign bl = prev_pix_q;
  assign br = pix_in;

  // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    row_d       = row_q;
    cfg_err_d   = cfg_err_q;
    finish_d    = 1'b0;
    win_valid_d = win_valid_q;
    win_d       = win_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    prev_pix_d  = prev_pix_q;
    prev_old_d  = prev_old_q;

    if (win_hs) win_valid_d = 1'b0;

    if (accept) begin
      prev_pix_d = pix_in;
      prev_old_d = old_pix;
      if (last_col) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
      // Window parity is that of its top-left pixel (row-1, col-1), i.e. the inverse of row/col bit 0.
      if ((state_q == S_STREAM) && (col_q != '0)) begin
        win_valid_d = 1'b1;
        win_row_d   = row_q;
        win_col_d   = col_q;
        unique case ({~row_q[0], ~col_q[0]})
          2'b00:   win_d = {tl, tr, bl, br};
          2'b01:   win_d = {tr, tl, br, bl};
          2'b10:   win_d = {bl, br, tl, tr};
          default: win_d = {br, bl, tr, tl};
        endcase
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          w_d       = image_width;
          h_d       = image_height;
          col_d     = '0;
          row_d     = '0;
          cfg_err_d = 1'b0;
          if ((image_width < TWO) || (image_height < TWO) || (image_width > MAX_W)) begin
            cfg_err_d = 1'b1;
            finish_d  = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (accept && last_col) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept && last_col && last_row) state_d = S_DONE;
      end
      default: begin
        // The final window is already in the output register; leave once it drains.
        if (!win_valid_q || win_ready) begin
          state_d  = S_IDLE;
          finish_d = 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      cfg_err_q   <= 1'b0;
      finish_q    <= 1'b0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      prev_pix_q  <= '0;
      prev_old_q  <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cfg_err_q   <= cfg_err_d;
      finish_q    <= finish_d;
      win_valid_q <= win_valid_d;
      win_q       <= win_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      prev_pix_q  <= prev_pix_d;
      prev_old_q  <= prev_old_d;
    end
  end

  // NOTE: the row cache has no reset so it can map onto a RAM; its contents are rewritten before being read.
  always_ff @(posedge clk) begin
    if (accept) cache[col_q[ADDR_W-1:0]] <= pix_in;
  end

`ifdef BAYER_WIN_STATS_EN
  logic [2*DIM_W-1:0] win_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && start_edge) begin
      win_cnt_q <= '0;
    end else if (win_hs && (win_cnt_q != '1)) begin
      win_cnt_q <= win_cnt_q + 1'b1;
    end
  end

  assign win_count = win_cnt_q;
`else
  assign win_count = '0;
`endif

  assign win_out     = win_q;
  assign win_row     = win_row_q;
  assign win_col     = win_col_q;
  assign win_valid   = win_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign finish_flag = finish_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_bayer_window_engine.sv
// Self-checking bench for bayer_window_engine: random frames against a Bayer-colour reference model.
module tb_bayer_window_engine;
  localparam int PIX_W     = 8;
  localparam int DIM_W     = 13;
  localparam int MAX_WIDTH = 4096;

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic                 start;
  logic [DIM_W-1:0]     image_width, image_height;
  logic [PIX_W-1:0]     pix_in;
  logic                 pix_in_valid;
  logic                 pix_in_ready;
  logic [4*PIX_W-1:0]   win_out;
  logic [DIM_W-1:0]     win_row, win_col;
  logic                 win_valid;
  logic                 win_ready;
  logic                 busy, finish_flag, cfg_err;
  logic [2*DIM_W-1:0]   win_count;

  always #5 clk = ~clk;

  bayer_window_engine #(.PIX_W(PIX_W), .DIM_W(DIM_W), .MAX_WIDTH(MAX_WIDTH)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .image_width(image_width), .image_height(image_height),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .win_out(win_out), .win_row(win_row), .win_col(win_col),
    .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy), .finish_flag(finish_flag), .cfg_err(cfg_err), .win_count(win_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int                 img[];
  logic [4*PIX_W-1:0] exp_win[$];
  int                 exp_row[$], exp_col[$];
  logic [4*PIX_W-1:0] obs_win[$];

  // Each pixel lands in the slot of its own Bayer colour: even/even R, even/odd G1, odd/even G2, odd/odd B.
  function automatic void build_model(input int w, input int h);
    logic [PIX_W-1:0] slot [4];
    int y, x;
    exp_win.delete(); exp_row.delete(); exp_col.delete();
    for (int r = 1; r < h; r++) begin
      for (int c = 1; c < w; c++) begin
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            y = r - 1 + dy;
            x = c - 1 + dx;
            slot[3 - 2*(y%2) - (x%2)] = PIX_W'(img[y*w + x]);
          end
        end
        exp_win.push_back({slot[3], slot[2], slot[1], slot[0]});
        exp_row.push_back(r);
        exp_col.push_back(c);
      end
    end
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pix_in_ready"}, pix_in_ready, 0);
    check({tag, "_finish"}, finish_flag, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_win_out"}, win_out, 0);
    check({tag, "_win_row"}, win_row, 0);
    check({tag, "_win_col"}, win_col, 0);
    check({tag, "_win_count"}, win_count, 0);
  endtask

  task automatic run_frame(input int w, input int h, input bit toggle, input bit gaps, input int abort_at);
    int n_acc = 0, extra = 0, n_fin = 0, n_win = 0, fin_cyc = 0;
    int budget = 4*w*h + 100;
    int exp_cnt;
    bit held_v = 1'b0, prev_busy = 1'b0;
    logic [4*PIX_W-1:0] held_w = '0;
    build_model(w, h);
    obs_win.delete();
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk);
      #1;
      if (abort_at > 0 && n_acc >= abort_at) begin
        pix_in_valid = 1'b0;
        return;
      end
      start        = (cyc == 0);
      image_width  = DIM_W'(w);
      image_height = DIM_W'(h);
      if (n_acc < w*h) begin
        pix_in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        pix_in       = PIX_W'(img[n_acc]);
      end else begin
        pix_in_valid = 1'b1;
        pix_in       = PIX_W'($urandom);
      end
      win_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (cyc == 1) begin
        check("cfg_err_clear", cfg_err, 0);
        check("win_count_clear", win_count, 0);
      end
      if (held_v) begin
        check("win_valid_hold", win_valid, 1);
        check("win_out_hold", win_out, held_w);
      end
      if (win_valid && win_ready) begin
        if (exp_win.size() == 0) begin
          check("extra_window", 1, 0);
        end else begin
          check("win_out", win_out, exp_win.pop_front());
          check("win_row", win_row, exp_row.pop_front());
          check("win_col", win_col, exp_col.pop_front());
        end
        obs_win.push_back(win_out);
        n_win++;
        held_v = 1'b0;
      end else if (win_valid) begin
        held_v = 1'b1;
        held_w = win_out;
      end else begin
        held_v = 1'b0;
      end
      if (pix_in_valid && pix_in_ready) begin
        if (n_acc < w*h) n_acc++;
        else extra++;
      end
      if (finish_flag) begin
        n_fin++;
        check("busy_at_finish", busy, 0);
        check("busy_before_finish", prev_busy, 1);
        fin_cyc = cyc;
      end
      prev_busy = busy;
      if (n_fin > 0 && cyc >= fin_cyc + 3) break;
    end
    pix_in_valid = 1'b0;
    if (n_fin == 0) check("finish_timeout", 0, 1);
    check("finish_pulses", n_fin, 1);
    check("window_total", n_win, (w-1)*(h-1));
    check("pixels_accepted", n_acc, w*h);
    check("extra_pixels", extra, 0);
    check("model_left", exp_win.size(), 0);
    check("cfg_err_frame", cfg_err, 0);
`ifdef BAYER_WIN_STATS_EN
    exp_cnt = (w-1)*(h-1);
`else
    exp_cnt = 0;
`endif
    check("win_count_final", win_count, exp_cnt);
  endtask

  task automatic cfg_bad(input int w, input int h);
    bit saw_rdy = 1'b0, saw_win = 1'b0;
    int n_fin = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk);
      #1;
      start        = (cyc == 0);
      image_width  = DIM_W'(w);
      image_height = DIM_W'(h);
      pix_in_valid = 1'b1;
      pix_in       = PIX_W'($urandom);
      win_ready    = 1'b1;
      @(negedge clk);
      if (pix_in_ready) saw_rdy = 1'b1;
      if (win_valid) saw_win = 1'b1;
      if (finish_flag) n_fin++;
    end
    pix_in_valid = 1'b0;
    check("cfg_err_set", cfg_err, 1);
    check("cfg_finish_pulses", n_fin, 1);
    check("cfg_ready_seen", saw_rdy, 0);
    check("cfg_window_seen", saw_win, 0);
    check("cfg_busy", busy, 0);
  endtask

  task automatic fill_random(input int n);
    img = new[n];
    foreach (img[i]) img[i] = $urandom_range(0, (1 << PIX_W) - 1);
  endtask

  initial begin
    int w, h;
    n_rst = 1'b0; start = 1'b0; image_width = '0; image_height = '0;
    pix_in = '0; pix_in_valid = 1'b0; win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Sequential 4x3 frame with free-flowing output
    img = new[12];
    foreach (img[i]) img[i] = i;
    run_frame(4, 3, 1'b0, 1'b0, 0);
    if (obs_win.size() >= 6) begin
      check("first_window", obs_win[0], 32'h0001_0405);
      check("odd_odd_R", obs_win[4][31:24], 10);
      check("odd_odd_B", obs_win[4][7:0], 5);
    end else begin
      check("seq_window_count", obs_win.size(), 6);
    end

    // Same frame under back-pressure and input gaps
    run_frame(4, 3, 1'b1, 1'b1, 0);

    for (int k = 0; k < 3; k++) begin
      w = $urandom_range(2, 9);
      h = $urandom_range(2, 6);
      fill_random(w*h);
      run_frame(w, h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    cfg_bad(1, 5);
    cfg_bad(MAX_WIDTH + 1, 3);
    cfg_bad(6, 1);
    fill_random(6);
    run_frame(3, 2, 1'b0, 1'b1, 0);

    // Full-width frame exercises the last row-cache entry
    fill_random(2*MAX_WIDTH);
    run_frame(MAX_WIDTH, 2, 1'b0, 1'b0, 0);
    if (obs_win.size() > 0)
      check("wrap_TR", obs_win[obs_win.size()-1][3*PIX_W-1:2*PIX_W], img[MAX_WIDTH-1]);

    // Abort at row 1 / col 2, then a clean frame
    img = new[12];
    foreach (img[i]) img[i] = i + 100;
    run_frame(4, 3, 1'b0, 1'b0, 6);
    #2;
    n_rst = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    fill_random(12);
    run_frame(4, 3, 1'b1, 1'b1, 0);

    fill_random(20);
    run_frame(5, 4, 1'b0, 1'b1, 0);
    fill_random(4);
    run_frame(2, 2, 1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
